// File: rtl/hazard_stall_ctrl.sv
// Purpose : load-use stall controller for the 5-stage MIPS pipeline, with memory-wait freeze and flush abort.
// Latency : stall outputs are combinational from the inputs and FSM state; the stall counter updates one cycle later.
// Backpress: a pending dmem access freezes the whole pipe; load bubbles resume once the access is acknowledged.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), synchronous active-high reset
//   IDEX_MemRead_i, IDEX_RT_i     load in ID/EX and its destination register
//   IFID_RS_i, IFID_RT_i          ID-stage source registers
//   IFID_UsesRT_i                 ID instruction actually reads RT
//   dmem_req_i, dmem_ack_i        MEM-stage data access request / completion
//   flush_i                       pipeline redirect, aborts a pending load stall
//   IFID_hazard_o, hazard_pc_o    hold IF/ID and PC
//   hazard_MUX_o                  zero ID/EX control (bubble)
//   mem_stall_o                   freeze ID/EX, EX/MEM, MEM/WB
//   stall_cnt_o                   saturating count of stalled cycles since reset
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RT_i,
  input  logic [REG_AW-1:0] IFID_RS_i,
  input  logic [REG_AW-1:0] IFID_RT_i,
  input  logic              IFID_UsesRT_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  input  logic              flush_i,
  output logic              IFID_hazard_o,
  output logic              hazard_pc_o,
  output logic              hazard_MUX_o,
  output logic              mem_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int REM_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {
    IDLE,
    LOAD_STALL
  } state_t;

  state_t             state_q;
  logic [REM_W-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic hit;
  logic mem_wait;
  logic ls;
  logic hold_any;

  // $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hit = IDEX_MemRead_i && (IDEX_RT_i != '0) &&
               ((IDEX_RT_i == IFID_RS_i) || (IFID_UsesRT_i && (IDEX_RT_i == IFID_RT_i)));

  // A same-cycle ack is a zero-wait access and must not freeze anything.
  assign mem_wait = dmem_req_i && !dmem_ack_i;

  // Once in LOAD_STALL the load has already moved on; the remaining bubbles
  // are owed regardless of what ID/EX currently holds.
  assign ls = ((state_q == IDLE) && hit) || (state_q == LOAD_STALL);

  // The memory freeze takes priority over bubbles: the bubble is deferred
  // until the first cycle the memory is no longer waiting.
  assign hold_any      = !rst_i && (mem_wait || (ls && !flush_i));
  assign hazard_MUX_o  = !rst_i && ls && !mem_wait && !flush_i;
  assign IFID_hazard_o = hold_any;
  assign hazard_pc_o   = hold_any;
  assign mem_stall_o   = !rst_i && mem_wait;
  assign stall_cnt_o   = cnt_q;

  // Saturating increment: sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_any && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush_i) begin
        // Redirect discards the dependent instruction, even mid-freeze.
        state_q <= IDLE;
        rem_q   <= '0;
      end else if (!mem_wait) begin
        case (state_q)
          IDLE: begin
            // With a single bubble the IDLE hit cycle covers the whole stall.
            if (hit && (LOAD_LAT > 1)) begin
              state_q <= LOAD_STALL;
              rem_q   <= REM_W'(LOAD_LAT - 1);
            end
          end
          LOAD_STALL: begin
            if (rem_q == REM_W'(1)) begin
              state_q <= IDLE;
              rem_q   <= '0;
            end else begin
              rem_q <= rem_q - REM_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            rem_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
